// File: rtl/elev_pkg.sv
// Shared types and constants for the elevator car controller.
package elev_pkg;

  // Car controller states; encoding is exported on state_o for debug.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    EVAL      = 3'd3,
    DOOR_OPEN = 3'd4
  } state_e;

  // Direction modes from the request processor (2'b11 behaves as stop).
  localparam logic [1:0] MODE_STOP = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;

  // One-hot floor positions.
  localparam logic [3:0] FLOOR1 = 4'b0001;
  localparam logic [3:0] FLOOR2 = 4'b0010;
  localparam logic [3:0] FLOOR3 = 4'b0100;
  localparam logic [3:0] FLOOR4 = 4'b1000;

endpackage

// File: rtl/tick_timer.sv
// Down-counter shared between travel and dwell timing. Loads take priority
// over force_zero; the count saturates at zero so it can never underflow.
module tick_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_force_zero,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // Count register: load, force to zero, or decrement towards zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_force_zero) begin
      r_count <= '0;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/car_motion_ctrl.sv
// Car-side executor: moves the car one floor at a time, opens the door on a
// request hit and reports one-hot position, door and motion status.
module car_motion_ctrl
  import elev_pkg::*;
#(
  parameter int unsigned TRAVEL_TICKS = 64,
  parameter int unsigned DWELL_TICKS  = 96,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ud_mode,
  input  logic [3:0] eff_req,
  input  logic       open_btn,
  input  logic       close_btn,
  output logic [3:0] position,
  output logic       door_open,
  output logic       moving_up,
  output logic       moving_down,
  output logic       arrive,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] TravelLoad = CNT_W'(TRAVEL_TICKS - 1);
  localparam logic [CNT_W-1:0] DwellLoad  = CNT_W'(DWELL_TICKS - 1);

  state_e           r_state, w_state_d;
  logic [3:0]       r_position, w_position_d;
  logic             r_dir_up, w_dir_up_d;
  logic             r_door_open, r_arrive;
  logic             w_hit, w_go_up, w_go_dn;
  logic             w_load, w_force_zero, w_zero;
  logic [CNT_W-1:0] w_load_val;

  assign w_hit   = |(eff_req & r_position);
  assign w_go_up = (ud_mode == MODE_UP) && (r_position != FLOOR4);
  assign w_go_dn = (ud_mode == MODE_DOWN) && (r_position != FLOOR1);

  tick_timer #(
    .CNT_W (CNT_W)
  ) u_tick_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_load),
    .i_load_val   (w_load_val),
    .i_force_zero (w_force_zero),
    .o_zero       (w_zero)
  );

  // Next-state, position update and timer control.
  always_comb begin
    w_state_d    = r_state;
    w_position_d = r_position;
    w_dir_up_d   = r_dir_up;
    w_load       = 1'b0;
    w_load_val   = TravelLoad;
    w_force_zero = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_hit || open_btn) begin
          w_state_d  = DOOR_OPEN;
          w_load     = 1'b1;
          w_load_val = DwellLoad;
        end else if (w_go_up) begin
          w_state_d  = MOVE_UP;
          w_dir_up_d = 1'b1;
          w_load     = 1'b1;
        end else if (w_go_dn) begin
          w_state_d  = MOVE_DOWN;
          w_dir_up_d = 1'b0;
          w_load     = 1'b1;
        end
      end
      MOVE_UP: begin
        if (w_zero) begin
          // Guard keeps position one-hot even if entered at the top floor.
          if (r_position != FLOOR4) w_position_d = r_position << 1;
          w_state_d = EVAL;
        end
      end
      MOVE_DOWN: begin
        if (w_zero) begin
          if (r_position != FLOOR1) w_position_d = r_position >> 1;
          w_state_d = EVAL;
        end
      end
      EVAL: begin
        if (w_hit) begin
          w_state_d  = DOOR_OPEN;
          w_load     = 1'b1;
          w_load_val = DwellLoad;
        end else if (r_dir_up && w_go_up) begin
          w_state_d = MOVE_UP;
          w_load    = 1'b1;
        end else if (!r_dir_up && w_go_dn) begin
          w_state_d = MOVE_DOWN;
          w_load    = 1'b1;
        end else begin
          w_state_d = IDLE;
        end
      end
      DOOR_OPEN: begin
        if (open_btn || w_hit) begin
          w_load     = 1'b1;
          w_load_val = DwellLoad;
        end else if (w_zero) begin
          w_state_d = IDLE;
        end else if (close_btn) begin
          w_force_zero = 1'b1;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // State, position and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_position  <= FLOOR1;
      r_dir_up    <= 1'b1;
      r_door_open <= 1'b0;
      r_arrive    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_position  <= w_position_d;
      r_dir_up    <= w_dir_up_d;
      r_door_open <= (w_state_d == DOOR_OPEN);
      r_arrive    <= (w_state_d == EVAL);
    end
  end

  assign position    = r_position;
  assign door_open   = r_door_open;
  assign arrive      = r_arrive;
  assign state_o     = r_state;
  assign moving_up   = (r_state == MOVE_UP);
  assign moving_down = (r_state == MOVE_DOWN);

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Bench for car_motion_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a floor/phase/time-remaining model.
module tb_car_motion_ctrl;

  localparam int unsigned Travel = 4;
  localparam int unsigned Dwell  = 6;

  // Phase codes as exposed on state_o.
  localparam int PIdle = 0, PUp = 1, PDn = 2, PEval = 3, PDoor = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] ud_mode;
  logic [3:0] eff_req;
  logic       open_btn, close_btn;
  logic [3:0] position;
  logic       door_open, moving_up, moving_down, arrive;
  logic [2:0] state_o;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: floor number, phase, cycles left in the phase, travel direction.
  int m_floor, m_phase, m_left;
  bit m_dir_up;

  car_motion_ctrl #(
    .TRAVEL_TICKS (Travel),
    .DWELL_TICKS  (Dwell),
    .CNT_W        (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ud_mode     (ud_mode),
    .eff_req     (eff_req),
    .open_btn    (open_btn),
    .close_btn   (close_btn),
    .position    (position),
    .door_open   (door_open),
    .moving_up   (moving_up),
    .moving_down (moving_down),
    .arrive      (arrive),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_pos();
    logic [3:0] p;
    p = 4'b0001 << (m_floor - 1);
    return p;
  endfunction

  task automatic model_reset();
    m_floor  = 1;
    m_phase  = PIdle;
    m_left   = 0;
    m_dir_up = 1'b1;
  endtask

  task automatic model_step();
    bit hit, up_ok, dn_ok;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hit   = eff_req[2'(m_floor - 1)];
    up_ok = (ud_mode == 2'b01) && (m_floor < 4);
    dn_ok = (ud_mode == 2'b10) && (m_floor > 1);
    case (m_phase)
      PIdle: begin
        if (hit || open_btn) begin
          m_phase = PDoor; m_left = Dwell;
        end else if (up_ok) begin
          m_phase = PUp; m_dir_up = 1'b1; m_left = Travel;
        end else if (dn_ok) begin
          m_phase = PDn; m_dir_up = 1'b0; m_left = Travel;
        end
      end
      PUp, PDn: begin
        if (m_left == 1) begin
          m_floor = (m_phase == PUp) ? m_floor + 1 : m_floor - 1;
          m_phase = PEval;
        end else begin
          m_left--;
        end
      end
      PEval: begin
        if (hit) begin
          m_phase = PDoor; m_left = Dwell;
        end else if (m_dir_up && up_ok) begin
          m_phase = PUp; m_left = Travel;
        end else if (!m_dir_up && dn_ok) begin
          m_phase = PDn; m_left = Travel;
        end else begin
          m_phase = PIdle;
        end
      end
      default: begin
        if (open_btn || hit) m_left = Dwell;
        else if (m_left == 1) m_phase = PIdle;
        else if (close_btn) m_left = 1;
        else m_left--;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (state_o != 3'd0 && n < 60) begin
      tick();
      n++;
    end
    check(name, 32'(state_o), 32'd0);
  endtask

  // Asynchronous reset mid-cycle, released on a falling edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_pos", 32'(position), 32'h1);
    check("async_rst_state", 32'(state_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("position", 32'(position), 32'(exp_pos()));
      check("door_open", 32'(door_open), 32'(m_phase == PDoor));
      check("moving_up", 32'(moving_up), 32'(m_phase == PUp));
      check("moving_down", 32'(moving_down), 32'(m_phase == PDn));
      check("arrive", 32'(arrive), 32'(m_phase == PEval));
      check("state_o", 32'(state_o), 32'(m_phase));
    end
  end

  initial begin
    int cnt;
    rst_n = 1'b0; ud_mode = 2'b00; eff_req = 4'b0000;
    open_btn = 1'b0; close_btn = 1'b0;
    model_reset();
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Reset state held, then reset during MOVE_UP.
    repeat (20) tick();
    check("t1_idle_state", 32'(state_o), 32'd0);
    check("t1_idle_pos", 32'(position), 32'h1);
    check("t1_idle_door", 32'(door_open), 32'd0);
    ud_mode = 2'b01;
    tick(); tick();
    check("t1_moving", 32'(moving_up), 32'd1);
    async_reset();
    check("t1_after_rst_mu", 32'(moving_up), 32'd0);
    ud_mode = 2'b00;
    tick();

    // 2. Single trip floor 1 -> floor 3.
    ud_mode = 2'b01; eff_req = 4'b0100;
    tick();
    check("t2_enter_up", 32'(state_o), 32'd1);
    repeat (3) tick();
    check("t2_pos_hold", 32'(position), 32'h1);
    tick();
    check("t2_pos_f2", 32'(position), 32'h2);
    check("t2_arrive_f2", 32'(arrive), 32'd1);
    tick();
    check("t2_reenter_up", 32'(state_o), 32'd1);
    repeat (4) tick();
    check("t2_pos_f3", 32'(position), 32'h4);
    check("t2_eval_f3", 32'(state_o), 32'd3);
    tick();
    check("t2_door", 32'(door_open), 32'd1);
    eff_req = 4'b0000; ud_mode = 2'b00;
    cnt = 0;
    repeat (12) begin
      if (door_open) cnt++;
      tick();
    end
    check("t2_dwell_len", 32'(cnt), 32'd6);
    check("t2_idle", 32'(state_o), 32'd0);

    // Go to floor 4 for the clamp and reversal tests.
    ud_mode = 2'b01; eff_req = 4'b1000;
    repeat (6) tick();
    eff_req = 4'b0000; ud_mode = 2'b00;
    wait_idle("t4_setup_idle");
    check("t4_setup_pos", 32'(position), 32'h8);

    // 4. Top-floor clamp.
    ud_mode = 2'b01;
    repeat (5) tick();
    check("t4_clamp_state", 32'(state_o), 32'd0);
    check("t4_clamp_pos", 32'(position), 32'h8);

    // 3. Stop at floor 3 when the down request is withdrawn.
    ud_mode = 2'b10; eff_req = 4'b0001;
    tick();
    check("t3_enter_down", 32'(state_o), 32'd2);
    ud_mode = 2'b00; eff_req = 4'b0000;
    repeat (4) tick();
    check("t3_eval_pos", 32'(position), 32'h4);
    check("t3_arrive", 32'(arrive), 32'd1);
    tick();
    check("t3_stop_state", 32'(state_o), 32'd0);
    check("t3_stop_door", 32'(door_open), 32'd0);
    repeat (5) tick();
    check("t3_stay_pos", 32'(position), 32'h4);

    // 5. Door buttons.
    open_btn = 1'b1;
    tick();
    check("t5_open", 32'(door_open), 32'd1);
    repeat (9) tick();
    open_btn = 1'b0;
    cnt = 0;
    repeat (10) begin
      if (door_open) cnt++;
      tick();
    end
    check("t5_hold_release", 32'(cnt), 32'd6);
    open_btn = 1'b1;
    tick();
    open_btn = 1'b0;
    tick();
    close_btn = 1'b1;
    tick();
    close_btn = 1'b0;
    tick();
    check("t5_close_door", 32'(door_open), 32'd0);
    check("t5_close_state", 32'(state_o), 32'd0);
    open_btn = 1'b1; close_btn = 1'b1;
    repeat (8) tick();
    check("t5_both_door", 32'(door_open), 32'd1);
    check("t5_both_state", 32'(state_o), 32'd4);
    open_btn = 1'b0; close_btn = 1'b0;
    wait_idle("t5_idle");

    // 6. Hall call at the current floor while idle.
    ud_mode = 2'b10; eff_req = 4'b0010;
    repeat (6) tick();
    eff_req = 4'b0000; ud_mode = 2'b00;
    wait_idle("t6_setup_idle");
    check("t6_setup_pos", 32'(position), 32'h2);
    eff_req = 4'b0010;
    tick();
    check("t6_door", 32'(door_open), 32'd1);
    check("t6_no_up", 32'(moving_up), 32'd0);
    check("t6_no_down", 32'(moving_down), 32'd0);
    eff_req = 4'b0000;
    wait_idle("t6_idle");

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end else begin
        if ($urandom_range(0, 7) == 0) ud_mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) begin
          for (int b = 0; b < 4; b++) eff_req[b] = ($urandom_range(0, 5) == 0);
        end
        open_btn  = ($urandom_range(0, 15) == 0);
        close_btn = ($urandom_range(0, 9) == 0);
        tick();
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
